// File: rtl/ariane_pkg.sv
// Shared core types for the multiplier writeback buffer: core configuration record,
// default FIFO depth and the default-configuration entry layout.
package ariane_pkg;

    typedef struct packed {
        int unsigned XLEN;
        int unsigned TRANS_ID_BITS;
        int unsigned NUM_THREADS_LOG;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64, TRANS_ID_BITS: 3, NUM_THREADS_LOG: 2};

    localparam int unsigned MULT_WB_DEPTH = 4;

    // Entry layout for the default configuration; other configurations rebuild the same shape.
    typedef struct packed {
        logic [cva6_cfg_empty.XLEN-1:0]            result;
        logic [cva6_cfg_empty.TRANS_ID_BITS-1:0]   trans_id;
        logic [cva6_cfg_empty.NUM_THREADS_LOG-1:0] thread_id;
        logic                                      live;
    } mult_wb_entry_t;

endpackage

// File: rtl/mult_wb_buffer_if.sv
// Handshake bundle between the multiplier/issue/flush side and the writeback buffer.
// slave = the buffer, master = the surrounding pipeline.
interface mult_wb_buffer_if
    import ariane_pkg::*;
#(
    parameter int unsigned XLEN            = cva6_cfg_empty.XLEN,
    parameter int unsigned TRANS_ID_BITS   = cva6_cfg_empty.TRANS_ID_BITS,
    parameter int unsigned NUM_THREADS_LOG = cva6_cfg_empty.NUM_THREADS_LOG
);
    logic                       issue_valid_i;
    logic                       issue_ready_o;
    logic                       mult_valid_i;
    logic [XLEN-1:0]            mult_result_i;
    logic [TRANS_ID_BITS-1:0]   mult_trans_id_i;
    logic [NUM_THREADS_LOG-1:0] mult_thread_id_i;
    logic                       flush_i;
    logic [NUM_THREADS_LOG-1:0] flush_thread_i;
    logic                       wb_valid_o;
    logic                       wb_ready_i;
    logic [XLEN-1:0]            wb_result_o;
    logic [TRANS_ID_BITS-1:0]   wb_trans_id_o;
    logic [NUM_THREADS_LOG-1:0] wb_thread_id_o;

    modport slave (
        input  issue_valid_i, mult_valid_i, mult_result_i, mult_trans_id_i, mult_thread_id_i,
        input  flush_i, flush_thread_i, wb_ready_i,
        output issue_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_thread_id_o
    );

    modport master (
        output issue_valid_i, mult_valid_i, mult_result_i, mult_trans_id_i, mult_thread_id_i,
        output flush_i, flush_thread_i, wb_ready_i,
        input  issue_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_thread_id_o
    );
endinterface

// File: rtl/mult_wb_fifo.sv
// Circular result FIFO: DEPTH entries, head/tail pointers, occupancy count and a
// per-entry kill input that clears the live bit of stored entries.
module mult_wb_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH   = MULT_WB_DEPTH,
    parameter int unsigned THR_W   = cva6_cfg_empty.NUM_THREADS_LOG,
    parameter type         entry_t = mult_wb_entry_t
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push,
    input  entry_t                      push_entry,
    input  logic                        pop,
    input  logic [DEPTH-1:0]            kill,
    output entry_t                      head,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output logic [DEPTH-1:0][THR_W-1:0] thread_ids
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_reg [DEPTH];
    logic [PTR_W-1:0]   head_reg;
    logic [PTR_W-1:0]   tail_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               full;

    // A push into a slot overrides any kill aimed at that slot's stale contents.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                mem_reg[gi] <= '0;
            end else if (push && (tail_reg == PTR_W'(gi))) begin
                mem_reg[gi] <= push_entry;
            end else if (kill[gi]) begin
                mem_reg[gi].live <= 1'b0;
            end
        end
        assign thread_ids[gi] = mem_reg[gi].thread_id;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + PTR_W'(1);
            if (pop)  head_reg <= head_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[head_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end
endmodule

// File: rtl/mult_wb_buffer.sv
// Writeback buffer behind the pipelined multiplier: issue credit, flush-on-push and
// head presentation. Optional same-cycle bypass when empty: `define MULT_WB_BYPASS_EN.
module mult_wb_buffer
    import ariane_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
    parameter int unsigned DEPTH   = MULT_WB_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mult_wb_buffer_if.slave bus
);
    localparam int unsigned XLEN  = CVA6Cfg.XLEN;
    localparam int unsigned TID_W = CVA6Cfg.TRANS_ID_BITS;
    localparam int unsigned THR_W = CVA6Cfg.NUM_THREADS_LOG;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    // One slot stays in reserve for the issue that lands while ready is still high.
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH - 1);

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [TID_W-1:0] trans_id;
        logic [THR_W-1:0] thread_id;
        logic             live;
    } entry_t;

    logic                        push;
    logic                        pop;
    logic                        empty;
    logic [CNT_W-1:0]            count;
    entry_t                      push_entry;
    entry_t                      head;
    logic [DEPTH-1:0]            kill;
    logic [DEPTH-1:0][THR_W-1:0] thread_ids;
    logic                        incoming_dead;
    logic                        head_valid;
    logic                        inflight_reg;
    logic                        issue_ready_reg;
    logic [CNT_W:0]              credit_used;

    assign incoming_dead = bus.flush_i && (bus.mult_thread_id_i == bus.flush_thread_i);

    assign push_entry = '{result:    bus.mult_result_i,
                          trans_id:  bus.mult_trans_id_i,
                          thread_id: bus.mult_thread_id_i,
                          live:      !incoming_dead};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
        assign kill[gi] = bus.flush_i && (thread_ids[gi] == bus.flush_thread_i);
    end

    mult_wb_fifo #(
        .DEPTH   (DEPTH),
        .THR_W   (THR_W),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (kill),
        .head       (head),
        .count      (count),
        .empty      (empty),
        .thread_ids (thread_ids)
    );

    // Decided on the pre-flush live bit, so a head already on the bus completes its handshake.
    assign head_valid = !empty && head.live;
    assign pop        = !empty && (!head.live || bus.wb_ready_i);

`ifdef MULT_WB_BYPASS_EN
    logic bypass_sel;
    logic bypass_taken;

    assign bypass_sel   = empty && bus.mult_valid_i;
    assign bypass_taken = bypass_sel && !incoming_dead && bus.wb_ready_i;
    assign push         = bus.mult_valid_i && !bypass_taken;

    assign bus.wb_valid_o     = bypass_sel ? !incoming_dead       : head_valid;
    assign bus.wb_result_o    = bypass_sel ? bus.mult_result_i    : head.result;
    assign bus.wb_trans_id_o  = bypass_sel ? bus.mult_trans_id_i  : head.trans_id;
    assign bus.wb_thread_id_o = bypass_sel ? bus.mult_thread_id_i : head.thread_id;
`else
    assign push               = bus.mult_valid_i;
    assign bus.wb_valid_o     = head_valid;
    assign bus.wb_result_o    = head.result;
    assign bus.wb_trans_id_o  = head.trans_id;
    assign bus.wb_thread_id_o = head.thread_id;
`endif

    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_reg};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_reg    <= 1'b0;
            issue_ready_reg <= 1'b1;
        end else begin
            inflight_reg    <= bus.issue_valid_i && issue_ready_reg;
            issue_ready_reg <= credit_used < CREDIT_LIMIT;
        end
    end

    assign bus.issue_ready_o = issue_ready_reg;
endmodule

// File: tb/tb_mult_wb_buffer.sv
// Self-checking bench for mult_wb_buffer: vector table, hand-written corner sequences
// and a randomized phase scored against a queue-level reference model.
module tb_mult_wb_buffer;
    import ariane_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [63:0] r;
        logic [2:0]  t;
        logic [1:0]  th;
        logic        live;
    } ent_t;

    typedef struct {
        logic [63:0] result;
        logic [2:0]  trans_id;
        logic [1:0]  thread_id;
        logic        flush;
        logic [1:0]  flush_thread;
        logic        exp_valid;
        logic [63:0] exp_result;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_wb_buffer_if #(.XLEN(64), .TRANS_ID_BITS(3), .NUM_THREADS_LOG(2)) bus ();

    mult_wb_buffer #(.CVA6Cfg(cva6_cfg_empty), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    string       phase  = "init";
    ent_t        q[$];
    logic [63:0] hs_q[$];
    bit          m_inflight;
    bit          m_ready;
    bit          last_fire;
    logic [63:0] nxt_res, cap_res;
    logic [2:0]  nxt_tid, cap_tid;
    logic [1:0]  nxt_thr, cap_thr;
    vec_t        vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s actual=%0h required=%0h", phase, name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_inflight = 1'b0;
        m_ready    = 1'b1;
    endtask

    // One clock: compare outputs against the model at the falling edge, advance the model,
    // then after the rising edge present the result of any multiply issued this cycle.
    task automatic tick();
        ent_t eh;
        bit   ev, in_dead, pop, store, nready;
        int   sz;
        @(negedge clk);
        in_dead = bus.flush_i && (bus.mult_thread_id_i == bus.flush_thread_i);
        sz = q.size();
        ev = 1'b0;
        eh = '0;
        if (sz > 0) begin
            ev = q[0].live;
            eh = q[0];
        end
`ifdef MULT_WB_BYPASS_EN
        if (sz == 0 && bus.mult_valid_i) begin
            ev = !in_dead;
            eh = '{r: bus.mult_result_i, t: bus.mult_trans_id_i, th: bus.mult_thread_id_i, live: 1'b1};
        end
`endif
        check("wb_valid", 64'(bus.wb_valid_o), 64'(ev));
        if (ev) begin
            check("wb_result", bus.wb_result_o, eh.r);
            check("wb_trans_id", 64'(bus.wb_trans_id_o), 64'(eh.t));
            check("wb_thread_id", 64'(bus.wb_thread_id_o), 64'(eh.th));
        end
        check("issue_ready", 64'(bus.issue_ready_o), 64'(m_ready));
        if (bus.wb_valid_o && bus.wb_ready_i) hs_q.push_back(bus.wb_result_o);

        last_fire = bus.issue_valid_i && bus.issue_ready_o;
        cap_res = nxt_res;
        cap_tid = nxt_tid;
        cap_thr = nxt_thr;

        pop    = (sz > 0) && (!q[0].live || bus.wb_ready_i);
        nready = (sz + int'(m_inflight)) < DEPTH - 1;
        m_inflight = bus.issue_valid_i && m_ready;
        if (bus.flush_i)
            foreach (q[i]) if (q[i].th == bus.flush_thread_i) q[i].live = 1'b0;
        if (pop) void'(q.pop_front());
        if (bus.mult_valid_i) begin
            store = 1'b1;
`ifdef MULT_WB_BYPASS_EN
            if (sz == 0 && bus.wb_ready_i && !in_dead) store = 1'b0;
`endif
            if (store)
                q.push_back('{r: bus.mult_result_i, t: bus.mult_trans_id_i,
                              th: bus.mult_thread_id_i, live: !in_dead});
        end
        m_ready = nready;

        @(posedge clk);
        #1;
        bus.mult_valid_i     = last_fire;
        bus.mult_result_i    = cap_res;
        bus.mult_trans_id_i  = cap_tid;
        bus.mult_thread_id_i = cap_thr;
        bus.flush_i          = 1'b0;
    endtask

    task automatic push_one(input logic [63:0] v, input logic [2:0] t, input logic [1:0] th);
        bus.issue_valid_i = 1'b1;
        nxt_res = v;
        nxt_tid = t;
        nxt_thr = th;
        tick();
        bus.issue_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int sent;
        vecs[0] = '{64'h1234, 3'd3, 2'd0, 1'b0, 2'd0, 1'b1, 64'h1234};
        vecs[1] = '{64'hdead_beef_0bad_f00d, 3'd7, 2'd3, 1'b0, 2'd0, 1'b1, 64'hdead_beef_0bad_f00d};
        vecs[2] = '{64'h5555, 3'd1, 2'd2, 1'b1, 2'd2, 1'b0, 64'h0};
        vecs[3] = '{64'h6666, 3'd2, 2'd1, 1'b1, 2'd2, 1'b1, 64'h6666};
        vecs[4] = '{64'h7777, 3'd4, 2'd1, 1'b1, 2'd1, 1'b0, 64'h0};
        vecs[5] = '{64'hffff_ffff_ffff_ffff, 3'd5, 2'd3, 1'b0, 2'd3, 1'b1, 64'hffff_ffff_ffff_ffff};

        bus.issue_valid_i = 0; bus.mult_valid_i = 0; bus.mult_result_i = 0;
        bus.mult_trans_id_i = 0; bus.mult_thread_id_i = 0; bus.flush_i = 0;
        bus.flush_thread_i = 0; bus.wb_ready_i = 0;
        nxt_res = 0; nxt_tid = 0; nxt_thr = 0;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        check("wb_valid", 64'(bus.wb_valid_o), 64'd0);
        check("issue_ready", 64'(bus.issue_ready_o), 64'd1);
        check("wb_result", bus.wb_result_o, 64'd0);
        check("wb_trans_id", 64'(bus.wb_trans_id_o), 64'd0);
        check("wb_thread_id", 64'(bus.wb_thread_id_o), 64'd0);
        rst = 1'b0;
        tick();

        phase = "vectors";
        foreach (vecs[i]) begin
            bus.wb_ready_i    = 1'b1;
            bus.issue_valid_i = 1'b1;
            nxt_res = vecs[i].result;
            nxt_tid = vecs[i].trans_id;
            nxt_thr = vecs[i].thread_id;
            tick();
            bus.issue_valid_i  = 1'b0;
            bus.flush_i        = vecs[i].flush;
            bus.flush_thread_i = vecs[i].flush_thread;
`ifdef MULT_WB_BYPASS_EN
            #1;
            check("vec_valid", 64'(bus.wb_valid_o), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check("vec_result", bus.wb_result_o, vecs[i].exp_result);
            tick();
`else
            tick();
            check("vec_valid", 64'(bus.wb_valid_o), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) check("vec_result", bus.wb_result_o, vecs[i].exp_result);
`endif
            repeat (3) tick();
            check("vec_idle", 64'(bus.wb_valid_o), 64'd0);
        end

        phase = "backpressure";
        bus.wb_ready_i = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            bus.issue_valid_i = 1'b1;
            nxt_res = 64'(n + 1);
            nxt_tid = 3'(n);
            nxt_thr = 2'd0;
            tick();
            if (last_fire) n++;
        end
        bus.issue_valid_i = 1'b0;
        repeat (3) tick();
        check("ready_low", 64'(bus.issue_ready_o), 64'd0);
        check("held_result", bus.wb_result_o, 64'd1);
        hs_q.delete();
        bus.wb_ready_i = 1'b1;
        repeat (n + 3) tick();
        check("drain_count", 64'(hs_q.size()), 64'(n));
        for (int k = 0; k < hs_q.size() && k < n; k++) check("drain_order", hs_q[k], 64'(k + 1));
        check("ready_back", 64'(bus.issue_ready_o), 64'd1);

        phase = "thread_flush";
        bus.wb_ready_i = 1'b0;
        push_one(64'hA1, 3'd1, 2'd1);
        push_one(64'hB0, 3'd2, 2'd0);
        push_one(64'hA2, 3'd3, 2'd1);
        check("head_before", bus.wb_result_o, 64'hA1);
        bus.flush_i        = 1'b1;
        bus.flush_thread_i = 2'd1;
        tick();
        check("dead_head_hidden", 64'(bus.wb_valid_o), 64'd0);
        tick();
        check("survivor_valid", 64'(bus.wb_valid_o), 64'd1);
        check("survivor_data", bus.wb_result_o, 64'hB0);
        repeat (2) tick();
        hs_q.delete();
        bus.wb_ready_i = 1'b1;
        repeat (4) tick();
        check("flush_hs_count", 64'(hs_q.size()), 64'd1);
        check("flush_empty", 64'(bus.wb_valid_o), 64'd0);

        phase = "wrap";
        hs_q.delete();
        sent = 0;
        for (int k = 0; k < 200 && sent < 20; k++) begin
            bus.issue_valid_i = 1'b1;
            nxt_res = 64'(100 + sent);
            nxt_tid = 3'(sent);
            nxt_thr = 2'(sent);
            bus.wb_ready_i = k[0];
            tick();
            if (last_fire) sent++;
        end
        bus.issue_valid_i = 1'b0;
        bus.wb_ready_i    = 1'b1;
        repeat (12) tick();
        check("wrap_sent", 64'(sent), 64'd20);
        check("wrap_count", 64'(hs_q.size()), 64'd20);
        for (int k = 0; k < hs_q.size() && k < 20; k++) check("wrap_order", hs_q[k], 64'(100 + k));

        phase = "random";
        for (int k = 0; k < 400; k++) begin
            bus.issue_valid_i  = 1'($urandom_range(0, 1));
            nxt_res            = {$urandom, $urandom};
            nxt_tid            = 3'($urandom);
            nxt_thr            = 2'($urandom);
            bus.flush_i        = ($urandom_range(0, 7) == 0);
            bus.flush_thread_i = 2'($urandom);
            bus.wb_ready_i     = ($urandom_range(0, 9) < 7);
            tick();
        end
        bus.issue_valid_i = 1'b0;
        bus.wb_ready_i    = 1'b1;
        repeat (8) tick();

        phase = "mid_reset";
        bus.wb_ready_i = 1'b0;
        push_one(64'hC1, 3'd1, 2'd0);
        push_one(64'hC2, 3'd2, 2'd1);
        push_one(64'hC3, 3'd3, 2'd2);
        check("queued_valid", 64'(bus.wb_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        check("wb_valid", 64'(bus.wb_valid_o), 64'd0);
        check("issue_ready", 64'(bus.issue_ready_o), 64'd1);
        check("wb_result", bus.wb_result_o, 64'd0);
        model_reset();
        bus.mult_valid_i  = 1'b0;
        bus.issue_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.wb_ready_i = 1'b1;
        repeat (4) tick();
        check("post_reset_valid", 64'(bus.wb_valid_o), 64'd0);
        check("post_reset_ready", 64'(bus.issue_ready_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
